tnn_stream_classifier: RTL and testbench
========================================

Name: tnn_stream_classifier

Overview:
- Parametrised, sequential successor to the fixed 8×2-bit combinational CGP ternary classifiers.
- Accepts one FEAT_W-bit unsigned feature per cycle over a valid/ready stream.
- Accumulates N_HID ternary-weighted hidden-neuron sums in parallel, thresholds them, and popcount-votes the hidden bits into a 1-bit class.
- Sits between the feature quantiser stream and the result collector; one instance serves any dataset configuration (breastcancer, etc.) by parameter override.

Parameters:
- N_FEAT, 8: features per frame (≥2).
- FEAT_W, 2: feature width, unsigned.
- N_HID, 4: hidden ternary neurons (≥1).
- W_HID, all zeros: packed ternary weights, N_HID*N_FEAT*2 bits. Entry [h][f] is at bits (h*N_FEAT+f)*2 +: 2. Codes: 00=0, 01=+1, 11=−1, 10=0.
- H_THR, all zeros: packed signed hidden thresholds, N_HID*ACC_W bits, entry h at h*ACC_W +: ACC_W.
- OUT_THR, 1: class=1 when popcount(hidden) ≥ OUT_THR.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: asynchronous active-low reset.
- in_valid, in, 1: feature valid.
- in_ready, out, 1: block accepts a feature.
- in_data, in, FEAT_W: feature value.
- in_sof, in, 1: start of frame; qualifies in_data as feature index 0.
- out_valid, out, 1: result valid.
- out_ready, in, 1: result consumed.
- out_class, out, 1: classification.
- err_sof, out, 1: sticky frame-restart flag.

Behaviour:
- Derived widths:
  - ACC_W = $clog2(N_FEAT*(2^FEAT_W−1)+1)+1, signed. This holds ±N_FEAT*(2^FEAT_W−1) with no overflow.
  - IDX_W = $clog2(N_FEAT).
  - POP_W = $clog2(N_HID+1).
- Reset (async assert, sync deassert handled upstream) values:
  - State=IDLE; in_ready=1; out_valid=0; out_class=0; err_sof=0.
  - Accumulators=0; feature index=0.
- Handshake: a transfer occurs when in_valid&&in_ready. Similarly for out. out_class is stable while out_valid&&!out_ready.
- FSM:
  - IDLE: in_ready=1. A transfer with in_sof=1 moves to ACCUM with idx=1, acc[h] = w[h][0]*in_data. A transfer with in_sof=0 is dropped and counted as a protocol error: err_sof is set.
  - ACCUM: in_ready=1. Each transfer does acc[h] += w[h][idx]*in_data and idx++. The transfer with idx==N_FEAT−1 goes to EVAL.
  - ACCUM with in_sof=1 (early restart): acc[h] reloads from this feature as index 0, idx=1, err_sof is set, and the state stays ACCUM.
  - EVAL (1 cycle): in_ready=0. hid[h] = (acc[h] ≥ H_THR[h]), signed compare. out_class is registered as popcount(hid) ≥ OUT_THR. out_valid is set. Go to HOLD.
  - HOLD: in_ready=0. When out_ready is high, out_valid clears and the state goes to IDLE.
- Latency: the last feature is accepted in cycle t, EVAL is cycle t+1, and out_valid is high from cycle t+2. Back-to-back frames cost N_FEAT+2 cycles minimum.
- Weight multiply is only add, subtract or skip; no multipliers.
- err_sof clears only on reset.
- in_valid with in_ready=0 is ignored. The data must be held by the source.
- Reset mid-frame or in HOLD discards all state immediately; no result is emitted.

Optional Feature:
- TNN_SCORE_OUT_EN defined:
  - Adds output port out_score (POP_W), the popcount of hidden bits registered in EVAL.
  - out_score is valid with out_valid and resets to 0.
- Undefined: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Package tnn_pkg holds:
  - Ternary code localparams T_ZERO, T_POS, T_NEG.
  - A function tern_apply(code, value) returning the signed contribution.
  - Functions acc_width(n_feat, feat_w) and popcount.
  - An FSM state enum {IDLE, ACCUM, EVAL, HOLD}.
- Sub-module tnn_neuron_acc: one signed accumulator with load/add ports and threshold compare, instantiated N_HID times via generate.

Test Plan:
- All tests use override N_FEAT=4, FEAT_W=2, N_HID=2. h0 weights are all +1 and h1 weights are all −1. H_THR = {6, −2}, OUT_THR=1.
- Frame 3,3,0,0 (sof on first) -> acc = {6, −6}, hid = 01, out_class=1 at cycle t+2.
- Frame 1,1,1,0 -> acc = {3, −3}, hid = 00, out_class=0. With TNN_SCORE_OUT_EN, out_score=0.
- Frame 0,0,0,0 -> acc = {0, 0}, hid = 10, out_class=1. in_ready=0 during EVAL/HOLD.
- Backpressure: out_ready low for 5 cycles after out_valid -> out_class held, in_ready=0 throughout, and the next frame is accepted in the cycle after out_ready.
- Frame 3,3 then sof with 1,1,1,0 -> err_sof=1 and the result equals the 1,1,1,0 case (class 0). Feature without sof in IDLE -> dropped, err_sof=1.
- Assert rst_n mid-ACCUM after 2 features -> out_valid=0, in_ready=1, err_sof=0. A subsequent 3,3,0,0 frame gives class 1.

Source files
------------

// File: rtl/tnn_stream_classifier_pkg.sv
// Shared definitions for the streaming ternary classifier: ternary weight
// codes, the width/popcount helpers and the control FSM state encoding.
// Optional feature macro used by the top: TNN_SCORE_OUT_EN.
package tnn_pkg;

    localparam logic [1:0] T_ZERO = 2'b00;
    localparam logic [1:0] T_POS  = 2'b01;
    localparam logic [1:0] T_NEG  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        EVAL,
        HOLD
    } state_t;

    // Signed accumulator width that holds +/- n_feat * (2^feat_w - 1).
    function automatic int acc_width(input int n_feat, input int feat_w);
        return $clog2(n_feat * ((1 << feat_w) - 1) + 1) + 1;
    endfunction

    // Ternary weight applied to an unsigned value: pass, negate or drop.
    // Code 2'b10 is unused and behaves as zero.
    function automatic logic signed [31:0] tern_apply(input logic [1:0] code,
                                                      input logic [31:0] value);
        case (code)
            T_POS:   return $signed(value);
            T_NEG:   return -$signed(value);
            default: return 32'sd0;
        endcase
    endfunction

    // Number of set bits in a (zero-extended) vector.
    function automatic int popcount(input logic [31:0] bits);
        int cnt;
        cnt = 0;
        for (int i = 0; i < 32; i++) begin
            cnt += int'(bits[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/tnn_stream_classifier_neuron_acc.sv
// One hidden ternary neuron: a signed running sum of weighted features and
// a signed compare of that sum against the neuron's fixed threshold.
module tnn_neuron_acc
    import tnn_pkg::*;
#(
    parameter int                       FEAT_W = 2,
    parameter int                       ACC_W  = 5,
    parameter logic signed [ACC_W-1:0]  THR    = '0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic              i_add,
    input  logic [1:0]        i_code,
    input  logic [FEAT_W-1:0] i_data,
    output logic              o_hit
);

    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_contrib;

    assign w_contrib = ACC_W'(tern_apply(i_code, 32'(i_data)));

    // Start a fresh sum on load (first feature of a frame), else accumulate.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
        end else if (i_load) begin
            r_acc <= w_contrib;
        end else if (i_add) begin
            r_acc <= r_acc + w_contrib;
        end
    end

    assign o_hit = (r_acc >= THR);

endmodule

// File: rtl/tnn_stream_classifier.sv
// Streaming ternary neural-network classifier. Takes one feature per cycle,
// accumulates N_HID ternary-weighted sums in parallel, thresholds them and
// votes the hidden bits into a single class bit.
// Optional: define TNN_SCORE_OUT_EN to add the o_out_score popcount output.
module tnn_stream_classifier
    import tnn_pkg::*;
#(
    parameter int N_FEAT  = 8,
    parameter int FEAT_W  = 2,
    parameter int N_HID   = 4,
    parameter logic [N_HID*N_FEAT*2-1:0] W_HID = '0,
    parameter logic [N_HID*acc_width(N_FEAT, FEAT_W)-1:0] H_THR = '0,
    parameter int OUT_THR = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [FEAT_W-1:0] i_in_data,
    input  logic              i_in_sof,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic              o_out_class,
`ifdef TNN_SCORE_OUT_EN
    output logic [$clog2(N_HID+1)-1:0] o_out_score,
`endif
    output logic              o_err_sof
);

    localparam int ACC_W = acc_width(N_FEAT, FEAT_W);
    localparam int IDX_W = $clog2(N_FEAT);
    localparam int POP_W = $clog2(N_HID + 1);

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_out_class;
    logic               r_err_sof;
`ifdef TNN_SCORE_OUT_EN
    logic [POP_W-1:0]   r_score;
`endif

    logic               w_xfer;
    logic               w_load;
    logic               w_add;
    logic [IDX_W-1:0]   w_sel_idx;
    logic [N_HID-1:0]   w_hid;
    logic               w_class;

    assign w_xfer    = i_in_valid && r_in_ready;
    assign w_load    = w_xfer && i_in_sof && ((r_state == IDLE) || (r_state == ACCUM));
    assign w_add     = w_xfer && !i_in_sof && (r_state == ACCUM);
    assign w_sel_idx = w_load ? '0 : r_idx;

    genvar h;
    generate
        for (h = 0; h < N_HID; h++) begin : g_hid
            logic [1:0] w_code;

            assign w_code = W_HID[(h * N_FEAT + int'(w_sel_idx)) * 2 +: 2];

            tnn_neuron_acc #(
                .FEAT_W (FEAT_W),
                .ACC_W  (ACC_W),
                .THR    (H_THR[h*ACC_W +: ACC_W])
            ) u_neuron (
                .i_clk   (i_clk),
                .i_rst_n (i_rst_n),
                .i_load  (w_load),
                .i_add   (w_add),
                .i_code  (w_code),
                .i_data  (i_in_data),
                .o_hit   (w_hid[h])
            );
        end
    endgenerate

    assign w_class = (popcount(32'(w_hid)) >= OUT_THR);

    // Frame control: collect N_FEAT features, evaluate once, then hold the
    // result until the collector takes it. Stray or early sof sets err_sof.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_class <= 1'b0;
            r_err_sof   <= 1'b0;
`ifdef TNN_SCORE_OUT_EN
            r_score     <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_xfer) begin
                        if (i_in_sof) begin
                            r_state <= ACCUM;
                            r_idx   <= IDX_W'(1);
                        end else begin
                            r_err_sof <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (w_xfer) begin
                        if (i_in_sof) begin
                            r_idx     <= IDX_W'(1);
                            r_err_sof <= 1'b1;
                        end else if (r_idx == IDX_W'(N_FEAT - 1)) begin
                            r_state    <= EVAL;
                            r_idx      <= '0;
                            r_in_ready <= 1'b0;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                EVAL: begin
                    r_out_class <= w_class;
                    r_out_valid <= 1'b1;
`ifdef TNN_SCORE_OUT_EN
                    r_score     <= POP_W'(popcount(32'(w_hid)));
`endif
                    r_state     <= HOLD;
                end
                HOLD: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_class = r_out_class;
    assign o_err_sof   = r_err_sof;
`ifdef TNN_SCORE_OUT_EN
    assign o_out_score = r_score;
`endif

endmodule

// File: tb/tb_tnn_stream_classifier.sv
// Directed bench for tnn_stream_classifier with N_FEAT=4, FEAT_W=2, N_HID=2,
// h0 weights all +1, h1 weights all -1, thresholds {6, -2}, OUT_THR=1.
module tb_tnn_stream_classifier;

    // h0: 4 x 2'b01, h1: 4 x 2'b11
    localparam logic [15:0] W_HID = 16'hFF55;
    // h1 = -2 (5'b11110) in the upper slot, h0 = 6 (5'b00110) in the lower
    localparam logic [9:0]  H_THR = {5'b11110, 5'b00110};

    logic       clock;
    logic       rstN;
    logic       inValid;
    logic       inReady;
    logic [1:0] inData;
    logic       inSof;
    logic       outValid;
    logic       outReady;
    logic       outClass;
    logic       errSof;
`ifdef TNN_SCORE_OUT_EN
    logic [1:0] outScore;
`endif

    int checkCount = 0;
    int passCount  = 0;

    tnn_stream_classifier #(
        .N_FEAT  (4),
        .FEAT_W  (2),
        .N_HID   (2),
        .W_HID   (W_HID),
        .H_THR   (H_THR),
        .OUT_THR (1)
    ) dut (
        .i_clk       (clock),
        .i_rst_n     (rstN),
        .i_in_valid  (inValid),
        .o_in_ready  (inReady),
        .i_in_data   (inData),
        .i_in_sof    (inSof),
        .o_out_valid (outValid),
        .i_out_ready (outReady),
        .o_out_class (outClass),
`ifdef TNN_SCORE_OUT_EN
        .o_out_score (outScore),
`endif
        .o_err_sof   (errSof)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Present one feature and hold it until the block accepts it.
    task automatic applyStimulus(input logic [1:0] data, input logic sof);
        int waitCycles;
        waitCycles = 0;
        @(negedge clock);
        inValid = 1'b1;
        inData  = data;
        inSof   = sof;
        while (!inReady && waitCycles < 50) begin
            @(negedge clock);
            waitCycles++;
        end
        if (waitCycles >= 50) begin
            checkOutput("inReadyTimeout", 32'(inReady), 32'd1);
        end
        @(posedge clock);
        #1;
        inValid = 1'b0;
        inSof   = 1'b0;
    endtask

    // Send a full frame, check EVAL/HOLD timing, optional backpressure, then
    // consume the result.
    task automatic runFrame(input string tag, input logic [1:0] d0, input logic [1:0] d1,
                            input logic [1:0] d2, input logic [1:0] d3,
                            input logic expClass, input logic [1:0] expScore,
                            input int holdCycles);
        applyStimulus(d0, 1'b1);
        applyStimulus(d1, 1'b0);
        applyStimulus(d2, 1'b0);
        applyStimulus(d3, 1'b0);
        @(negedge clock);
        checkOutput({tag, "-evalValid"}, 32'(outValid), 32'd0);
        checkOutput({tag, "-evalReady"}, 32'(inReady), 32'd0);
        @(negedge clock);
        checkOutput({tag, "-valid"}, 32'(outValid), 32'd1);
        checkOutput({tag, "-class"}, 32'(outClass), 32'(expClass));
        checkOutput({tag, "-holdReady"}, 32'(inReady), 32'd0);
`ifdef TNN_SCORE_OUT_EN
        checkOutput({tag, "-score"}, 32'(outScore), 32'(expScore));
`else
        if (expScore > 2'd2) begin
            $display("[TB] note: score %0d out of range for %s", expScore, tag);
        end
`endif
        for (int i = 0; i < holdCycles; i++) begin
            @(negedge clock);
            checkOutput({tag, "-bpValid"}, 32'(outValid), 32'd1);
            checkOutput({tag, "-bpClass"}, 32'(outClass), 32'(expClass));
            checkOutput({tag, "-bpReady"}, 32'(inReady), 32'd0);
        end
        outReady = 1'b1;
        @(posedge clock);
        #1;
        outReady = 1'b0;
        checkOutput({tag, "-doneValid"}, 32'(outValid), 32'd0);
        checkOutput({tag, "-doneReady"}, 32'(inReady), 32'd1);
    endtask

    // Directed sequence covering reset, three frames, backpressure, sof
    // protocol errors and an asynchronous reset in the middle of a frame.
    initial begin
        rstN     = 1'b0;
        inValid  = 1'b0;
        inData   = 2'd0;
        inSof    = 1'b0;
        outReady = 1'b0;
        repeat (2) @(negedge clock);
        checkOutput("rstReady", 32'(inReady), 32'd1);
        checkOutput("rstValid", 32'(outValid), 32'd0);
        checkOutput("rstClass", 32'(outClass), 32'd0);
        checkOutput("rstErr", 32'(errSof), 32'd0);
`ifdef TNN_SCORE_OUT_EN
        checkOutput("rstScore", 32'(outScore), 32'd0);
`endif
        rstN = 1'b1;

        // acc {6,-6} -> hid 01 -> class 1
        runFrame("f3300", 2'd3, 2'd3, 2'd0, 2'd0, 1'b1, 2'd1, 0);
        // acc {3,-3} -> hid 00 -> class 0
        runFrame("f1110", 2'd1, 2'd1, 2'd1, 2'd0, 1'b0, 2'd0, 0);
        // acc {0,0} -> hid 10 -> class 1
        runFrame("f0000", 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 2'd1, 0);
        // Result held under five cycles of backpressure, next frame follows
        runFrame("bp", 2'd3, 2'd3, 2'd0, 2'd0, 1'b1, 2'd1, 5);
        runFrame("afterBp", 2'd1, 2'd1, 2'd1, 2'd0, 1'b0, 2'd0, 0);
        checkOutput("errBeforeRestart", 32'(errSof), 32'd0);

        // Early restart: the second sof frame replaces the partial one
        applyStimulus(2'd3, 1'b1);
        applyStimulus(2'd3, 1'b0);
        runFrame("restart", 2'd1, 2'd1, 2'd1, 2'd0, 1'b0, 2'd0, 0);
        checkOutput("errAfterRestart", 32'(errSof), 32'd1);

        // Clear the flag, then a feature without sof in IDLE is dropped
        @(negedge clock);
        rstN = 1'b0;
        @(negedge clock);
        checkOutput("errCleared", 32'(errSof), 32'd0);
        rstN = 1'b1;
        applyStimulus(2'd3, 1'b0);
        @(negedge clock);
        checkOutput("dropErr", 32'(errSof), 32'd1);
        checkOutput("dropReady", 32'(inReady), 32'd1);
        runFrame("afterDrop", 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 2'd1, 0);

        // Reset in the middle of a frame discards everything
        applyStimulus(2'd3, 1'b1);
        applyStimulus(2'd3, 1'b0);
        @(negedge clock);
        rstN = 1'b0;
        #1;
        checkOutput("midRstValid", 32'(outValid), 32'd0);
        checkOutput("midRstReady", 32'(inReady), 32'd1);
        checkOutput("midRstErr", 32'(errSof), 32'd0);
        @(negedge clock);
        rstN = 1'b1;
        runFrame("afterRst", 2'd3, 2'd3, 2'd0, 2'd0, 1'b1, 2'd1, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] simulation timeout");
    end

endmodule
